adder_share_arb: RTL

Round-robin arbiter that time-shares one registered signed adder between `NUM_REQ` requesters in the systolic-array datapath. Each requester presents a pair of signed operands with a valid/grant handshake. The arbiter picks at most one requester per cycle and issues its operands to the shared adder. One cycle later it returns the `DATA_WIDTH+1`-bit sum tagged with the requester index, holding the result under downstream backpressure.

---
 rtl/adder_share_arb.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/adder_share_arb.sv
// ---------------------------------------------------------------------------
// adder_share_arb
//
// Purpose
//   Time-shares one registered signed adder between NUM_REQ requesters.
//   At most one requester is granted per cycle. The granted operand pair is
//   sign-extended and summed, and the sum is registered together with the
//   requester index. The registered result is held while downstream
//   backpressures.
//
// Compile-time option
//   ADDER_ARB_RR_EN  defined   : round-robin arbitration starting at rr_ptr.
//                    undefined : fixed priority, lowest asserted index wins,
//                                and no rr_ptr state exists.
//
// Handshakes (valid/ready semantics, identical on both sides)
//   Input side : requester k's operands are consumed in a cycle where
//                i_req[k] && o_gnt[k]. A requester may hold i_req high and
//                wait, or drop it without a grant (nothing is consumed).
//                The grant never depends on i_data.
//   Output side: a result is transferred in a cycle where
//                o_valid && i_out_ready. While o_valid is high and
//                i_out_ready is low, o_valid/o_data/o_id are held stable.
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   i_en         in   global enable; low blocks new grants only
//   i_req        in   [NUM_REQ]               per-requester operand valid
//   i_data       in   [NUM_REQ*2*DATA_WIDTH]  requester k: slice
//                     [k*2*DATA_WIDTH +: 2*DATA_WIDTH], a = upper, b = lower
//   o_gnt        out  [NUM_REQ]       one-hot or zero grant (combinational)
//   o_valid      out  result valid (registered)
//   o_data       out  [DATA_WIDTH+1]  signed exact sum a+b (registered)
//   o_id         out  [ID_W]          index of the producing requester
//   i_out_ready  in   downstream ready
// ---------------------------------------------------------------------------
module adder_share_arb #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_en,
    input  logic [NUM_REQ-1:0]              i_req,
    input  logic [NUM_REQ*2*DATA_WIDTH-1:0] i_data,
    output logic [NUM_REQ-1:0]              o_gnt,
    output logic                            o_valid,
    output logic [DATA_WIDTH:0]             o_data,
    output logic [ID_W-1:0]                 o_id,
    input  logic                            i_out_ready
);

    // -----------------------------------------------------------------------
    // Output register state
    // -----------------------------------------------------------------------
    logic                  o_valid_q;
    logic                  o_valid_d;
    logic [DATA_WIDTH:0]   o_data_q;
    logic [DATA_WIDTH:0]   o_data_d;
    logic [ID_W-1:0]       o_id_q;
    logic [ID_W-1:0]       o_id_d;

    // -----------------------------------------------------------------------
    // Issue control
    // -----------------------------------------------------------------------
    logic                  any_req;
    logic                  slot_free;
    logic                  can_issue;
    logic                  accept;
    logic [ID_W-1:0]       winner;

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH:0]   sum;

    assign any_req   = |i_req;

    // The output register can take a new result when it is empty or when
    // its current content leaves this cycle. This is what allows one result
    // per cycle while i_out_ready stays high.
    assign slot_free = !o_valid_q || i_out_ready;

    // rst is folded in so that o_gnt is zero during reset. A requester must
    // never see its operands consumed in a reset cycle.
    assign can_issue = i_en && slot_free && !rst;

    // Every grant is also an accept, because a grant is only ever raised on
    // an asserted i_req bit.
    assign accept    = can_issue && any_req;

`ifdef ADDER_ARB_RR_EN
    // -----------------------------------------------------------------------
    // Round-robin winner selection
    // -----------------------------------------------------------------------
    // The request vector is rotated so that bit 0 corresponds to rr_ptr.
    // The lowest set bit of the rotated vector is the offset from rr_ptr.
    // Adding that offset back modulo NUM_REQ gives the absolute winner.
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    rr_ptr_d;
    logic [NUM_REQ-1:0] req_rot;
    logic [ID_W-1:0]    rot_off;
    logic [ID_W:0]      win_ext;

    always_comb begin
        req_rot = NUM_REQ'({i_req, i_req} >> rr_ptr_q);
        rot_off = '0;
        // Scanning downward leaves the lowest set bit as the final value.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_off = ID_W'(i);
            end
        end
        // Both terms are below NUM_REQ, so a single conditional subtract
        // completes the modulo.
        win_ext = {1'b0, rr_ptr_q} + {1'b0, rot_off};
        if (win_ext >= (ID_W + 1)'(NUM_REQ)) begin
            win_ext = win_ext - (ID_W + 1)'(NUM_REQ);
        end
        winner = win_ext[ID_W-1:0];
    end

    // The pointer moves one past the winner only on an accept. This covers
    // i_en low, stalls and idle cycles, which all leave it unchanged.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            if (winner == ID_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = winner + ID_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // -----------------------------------------------------------------------
    // Fixed-priority winner selection: the lowest asserted index wins
    // -----------------------------------------------------------------------
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                winner = ID_W'(i);
            end
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Grant vector
    // -----------------------------------------------------------------------
    always_comb begin
        o_gnt = '0;
        if (accept) begin
            o_gnt[winner] = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Operand mux and adder
    // -----------------------------------------------------------------------
    // i_data only reaches the output register, never a port directly, so
    // there is no combinational path from i_data to any output.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (winner == ID_W'(k)) begin
                op_a = i_data[k*2*DATA_WIDTH + DATA_WIDTH +: DATA_WIDTH];
                op_b = i_data[k*2*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        // Sign-extending by one bit makes the sum exact, so it cannot
        // overflow.
        sum = {op_a[DATA_WIDTH-1], op_a} + {op_b[DATA_WIDTH-1], op_b};
    end

    // -----------------------------------------------------------------------
    // Output register next state, in priority order:
    //   1. accept                  load the new result
    //   2. i_out_ready (no accept) drop valid; data and id hold
    //   3. otherwise               hold everything
    // -----------------------------------------------------------------------
    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_id_d    = o_id_q;
        if (accept) begin
            o_valid_d = 1'b1;
            o_data_d  = sum;
            o_id_d    = winner;
        end else if (i_out_ready) begin
            o_valid_d = 1'b0;
        end
    end

    // A pending result that has not been accepted downstream is discarded
    // on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_id_q    <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_id_q    <= o_id_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_id    = o_id_q;

endmodule
